// File: rtl/i2s_rate_sequencer_if.sv
// Request/status and APB signal bundle for i2s_rate_sequencer.
// The master modport is the sequencer side; slave is the requester / APB target side.
interface i2s_rate_sequencer_if;
   logic [1:0]  rate_req;
   logic        master_req;
   logic        req_valid;
   logic        req_ready;
   logic        busy;
   logic        done;
   logic        err;
   logic [1:0]  cur_rate;
   logic [4:0]  paddr;
   logic        psel;
   logic        penable;
   logic        pwrite;
   logic [31:0] pwdata;
   logic [31:0] prdata;
   logic        pready;

   modport master (
      input  rate_req, master_req, req_valid, prdata, pready,
      output req_ready, busy, done, err, cur_rate,
             paddr, psel, penable, pwrite, pwdata
   );

   modport slave (
      output rate_req, master_req, req_valid, prdata, pready,
      input  req_ready, busy, done, err, cur_rate,
             paddr, psel, penable, pwrite, pwdata
   );
endinterface

// File: rtl/i2s_rate_sequencer.sv
// Programs an I2S clock block over APB: write A, write B, settle, write C, optional readback.
// Define I2S_RATE_READBACK_EN to add the readback of REG1 after write C (sets err on mismatch).
module i2s_rate_sequencer #(
   parameter int unsigned SETTLE_CYCLES = 64,
   parameter logic [4:0]  REG1_ADDR     = 5'd0,
   parameter logic [4:0]  REG2_ADDR     = 5'd4
) (
   input  logic                  clk,
   input  logic                  reset,
   i2s_rate_sequencer_if.master  bus
);

`ifdef I2S_RATE_READBACK_EN
   localparam logic RB_EN = 1'b1;
`else
   localparam logic RB_EN = 1'b0;
`endif

   typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ACCESS, S_SETTLE, S_DONE} state_t;

   localparam logic [1:0]  STEP_A  = 2'd0;
   localparam logic [1:0]  STEP_B  = 2'd1;
   localparam logic [1:0]  STEP_C  = 2'd2;
   localparam logic [11:0] SETTLE_LOAD = 12'(SETTLE_CYCLES);

   state_t      r_state, w_state_nxt;
   logic [1:0]  r_step, w_step_nxt;
   logic [11:0] r_cnt, w_cnt_nxt;
   logic [1:0]  r_rate, r_cur_rate;
   logic        r_master, r_err, r_pwrite;
   logic [4:0]  r_paddr;
   logic [31:0] r_pwdata;

   logic        w_launch, w_rd_bad, w_accept;
   logic [1:0]  w_rate;
   logic        w_master;
   logic [4:0]  w_addr_l;
   logic [31:0] w_data_l, w_word_c;
   logic        w_wr_l;

   function automatic logic [31:0] word_a(input logic [1:0] rate);
      logic [7:0] bclk;
      logic       sel44;
      case (rate)
         2'd0:    begin bclk = 8'd3; sel44 = 1'b0; end
         2'd1:    begin bclk = 8'd1; sel44 = 1'b0; end
         2'd2:    begin bclk = 8'd5; sel44 = 1'b1; end
         default: begin bclk = 8'd2; sel44 = 1'b1; end
      endcase
      return {8'd0, bclk, 14'd0, sel44, 1'b0};
   endfunction

   function automatic logic [31:0] word_b(input logic [1:0] rate);
      logic [7:0] lr;
      case (rate)
         2'd0:    lr = 8'd15;
         2'd1:    lr = 8'd7;
         2'd2:    lr = 8'd23;
         default: lr = 8'd11;
      endcase
      return {16'd0, lr, lr};
   endfunction

   assign w_accept = (r_state == S_IDLE) && bus.req_valid;
   // The first launch happens in IDLE, before the request is latched.
   assign w_rate   = w_accept ? bus.rate_req   : r_rate;
   assign w_master = w_accept ? bus.master_req : r_master;
   assign w_word_c = word_a(r_rate) | {31'd0, r_master};

   always_comb begin
      w_state_nxt = r_state;
      w_step_nxt  = r_step;
      w_cnt_nxt   = r_cnt;
      w_launch    = 1'b0;
      w_rd_bad    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.req_valid) begin
               w_state_nxt = S_SETUP;
               w_step_nxt  = STEP_A;
               w_launch    = 1'b1;
            end
         end
         S_SETUP: w_state_nxt = S_ACCESS;
         S_ACCESS: begin
            if (bus.pready) begin
               // SETTLE doubles as the inter-transfer gap; it lasts r_cnt+1 cycles.
               case (r_step)
                  STEP_A: begin w_state_nxt = S_SETTLE; w_cnt_nxt = 12'd0; end
                  STEP_B: begin w_state_nxt = S_SETTLE; w_cnt_nxt = SETTLE_LOAD; end
                  STEP_C: begin
                     if (RB_EN) begin
                        w_state_nxt = S_SETTLE;
                        w_cnt_nxt   = 12'd0;
                     end else begin
                        w_state_nxt = S_DONE;
                     end
                  end
                  default: begin
                     w_state_nxt = S_DONE;
                     w_rd_bad    = RB_EN && (bus.prdata != w_word_c);
                  end
               endcase
            end
         end
         S_SETTLE: begin
            if (r_cnt == 12'd0) begin
               w_state_nxt = S_SETUP;
               w_step_nxt  = r_step + 2'd1;
               w_launch    = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt - 12'd1;
            end
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_addr_l = REG1_ADDR;
      w_wr_l   = 1'b1;
      w_data_l = word_a(w_rate) | {31'd0, w_master};
      case (w_step_nxt)
         STEP_A: w_data_l = word_a(w_rate);
         STEP_B: begin w_addr_l = REG2_ADDR; w_data_l = word_b(w_rate); end
         STEP_C: ;
         default: w_wr_l = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_step     <= STEP_A;
         r_cnt      <= 12'd0;
         r_rate     <= 2'd0;
         r_master   <= 1'b0;
         r_err      <= 1'b0;
         r_cur_rate <= 2'd0;
         r_paddr    <= 5'd0;
         r_pwdata   <= 32'd0;
         r_pwrite   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_step  <= w_step_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_accept) begin
            r_rate   <= bus.rate_req;
            r_master <= bus.master_req;
            r_err    <= 1'b0;
         end
         if (w_launch) begin
            r_paddr  <= w_addr_l;
            r_pwdata <= w_data_l;
            r_pwrite <= w_wr_l;
         end
         if (w_rd_bad)
            r_err <= 1'b1;
         // cur_rate becomes visible in the DONE cycle itself.
         if (w_state_nxt == S_DONE && r_state != S_DONE && !(r_err || w_rd_bad))
            r_cur_rate <= r_rate;
      end
   end

   assign bus.req_ready = (r_state == S_IDLE);
   assign bus.busy      = (r_state != S_IDLE);
   assign bus.done      = (r_state == S_DONE);
   assign bus.err       = r_err;
   assign bus.cur_rate  = r_cur_rate;
   assign bus.psel      = (r_state == S_SETUP) || (r_state == S_ACCESS);
   assign bus.penable   = (r_state == S_ACCESS);
   assign bus.paddr     = r_paddr;
   assign bus.pwdata    = r_pwdata;
   assign bus.pwrite    = r_pwrite;

endmodule

// File: tb/tb_i2s_rate_sequencer.sv
// Randomized bench for i2s_rate_sequencer: reference model builds the expected APB
// transfer list, duration and status from the rate table; a monitor records the bus.
module tb_i2s_rate_sequencer;
   localparam int S = 64;
`ifdef I2S_RATE_READBACK_EN
   localparam int RB = 1;
`else
   localparam int RB = 0;
`endif

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   i2s_rate_sequencer_if bus();

   i2s_rate_sequencer #(
      .SETTLE_CYCLES(S),
      .REG1_ADDR(5'd0),
      .REG2_ADDR(5'd4)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus.master)
   );

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   // model tables
   int bclk_t[4] = '{3, 1, 5, 2};
   int lr_t[4]   = '{15, 7, 23, 11};
   int s44_t[4]  = '{0, 0, 1, 1};
   int m_cur = 0;

   function automatic logic [31:0] m_word_a(input int r);
      return 32'(bclk_t[r] * 65536 + s44_t[r] * 2);
   endfunction
   function automatic logic [31:0] m_word_b(input int r);
      return 32'(lr_t[r] * 256 + lr_t[r]);
   endfunction

   // monitor / APB target
   logic [37:0] obs[$];
   logic [37:0] setup_snap = '0;
   logic        prev_psel = 1'b0;
   int waits = 0, busy_cnt = 0, done_cnt = 0, proto_err = 0;
   int mode = 0, stall_left = 0;
   logic [31:0] rd_data = '0;

   initial begin
      bus.pready = 1'b1;
      bus.prdata = '0;
      forever begin
         @(negedge clk);
         if (mode == 1)
            bus.pready = ($urandom_range(0, 2) != 0);
         else if (mode == 2 && bus.psel && bus.penable && bus.paddr == 5'd4 && stall_left > 0) begin
            bus.pready = 1'b0;
            stall_left--;
         end else
            bus.pready = 1'b1;
         bus.prdata = rd_data;
         if (!reset) begin
            if (bus.busy) busy_cnt++;
            if (bus.done) done_cnt++;
            if (bus.req_ready == bus.busy) proto_err++;
            if (bus.penable && !bus.psel) proto_err++;
            if (!bus.busy && bus.psel) proto_err++;
            if (bus.psel && !bus.penable) begin
               if (prev_psel) proto_err++;
               setup_snap = {bus.pwrite, bus.paddr, bus.pwdata};
            end
            if (bus.psel && bus.penable) begin
               if ({bus.pwrite, bus.paddr, bus.pwdata} != setup_snap) proto_err++;
               if (bus.pready) obs.push_back({bus.pwrite, bus.paddr, bus.pwdata});
               else waits++;
            end
         end
         prev_psel = bus.psel;
      end
   end

   task automatic wait_idle();
      int bound = 0;
      while (!bus.req_ready && bound < 1000) begin
         @(negedge clk);
         bound++;
      end
      chk("idle_timeout", 64'(bound < 1000), 64'd1);
   endtask

   task automatic run_seq(input int rate, input int master, input int md, input int corrupt, input int poke);
      logic [37:0] exp_q[$];
      logic [31:0] wc;
      int bound, settle_seen, exp_err;
      wc = m_word_a(rate) + 32'(master);
      exp_q.push_back({1'b1, 5'd0, m_word_a(rate)});
      exp_q.push_back({1'b1, 5'd4, m_word_b(rate)});
      exp_q.push_back({1'b1, 5'd0, wc});
      if (RB != 0) exp_q.push_back({1'b0, 5'd0, wc});
      rd_data = (corrupt != 0) ? 32'd0 : wc;
      wait_idle();
      obs.delete();
      waits = 0; busy_cnt = 0; done_cnt = 0; proto_err = 0;
      mode = md; stall_left = 3;
      bus.req_valid  = 1'b1;
      bus.rate_req   = 2'(rate);
      bus.master_req = 1'(master);
      @(negedge clk);
      bus.req_valid  = 1'b0;
      bus.rate_req   = 2'($urandom_range(0, 3));
      bus.master_req = 1'($urandom_range(0, 1));
      bound = 0;
      settle_seen = 0;
      while (!bus.done && bound < 5000) begin
         if (poke != 0 && bus.busy && !bus.psel) settle_seen++;
         if (poke != 0 && settle_seen == 10) begin
            bus.req_valid = 1'b1;
            bus.rate_req  = 2'd1;
         end else
            bus.req_valid = 1'b0;
         @(negedge clk);
         bound++;
      end
      bus.req_valid = 1'b0;
      chk("done_timeout", 64'(bound < 5000), 64'd1);
      repeat (3) @(negedge clk);
      mode = 0;
      exp_err = (RB != 0 && corrupt != 0) ? 1 : 0;
      if (exp_err == 0) m_cur = rate;
      chk("busy_cycles", 64'(busy_cnt), 64'(9 + S + waits + 3 * RB));
      if (md == 2) chk("stall_waits", 64'(waits), 64'd3);
      chk("done_pulses", 64'(done_cnt), 64'd1);
      chk("apb_protocol", 64'(proto_err), 64'd0);
      chk("n_xfers", 64'(obs.size()), 64'(exp_q.size()));
      foreach (exp_q[i])
         if (i < obs.size()) chk($sformatf("xfer%0d", i), 64'(obs[i]), 64'(exp_q[i]));
      chk("err", 64'(bus.err), 64'(exp_err));
      chk("cur_rate", 64'(bus.cur_rate), 64'(m_cur));
      chk("ready_after", 64'(bus.req_ready), 64'd1);
   endtask

   task automatic reset_mid_seq(input int rate);
      int bound = 0, n_b = 0;
      wait_idle();
      obs.delete();
      bus.req_valid = 1'b1;
      bus.rate_req  = 2'(rate);
      bus.master_req = 1'b1;
      @(negedge clk);
      bus.req_valid = 1'b0;
      while (!(bus.psel && bus.penable) && bound < 100) begin
         @(negedge clk);
         bound++;
      end
      chk("rst_reach_access", 64'(bound < 100), 64'd1);
      reset = 1'b1;
      @(negedge clk);
      chk("rst_psel", 64'(bus.psel), 64'd0);
      chk("rst_penable", 64'(bus.penable), 64'd0);
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_paddr", 64'(bus.paddr), 64'd0);
      chk("rst_pwdata", 64'(bus.pwdata), 64'd0);
      reset = 1'b0;
      m_cur = 0;
      repeat (S + 20) @(negedge clk);
      foreach (obs[i]) if (obs[i][36:32] == 5'd4) n_b++;
      chk("rst_no_write_b", 64'(n_b), 64'd0);
      chk("rst_cur_rate", 64'(bus.cur_rate), 64'd0);
      chk("rst_ready", 64'(bus.req_ready), 64'd1);
      chk("rst_err", 64'(bus.err), 64'd0);
   endtask

   initial begin
      bus.req_valid  = 1'b0;
      bus.rate_req   = 2'd0;
      bus.master_req = 1'b0;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_ready", 64'(bus.req_ready), 64'd1);
      chk("reset_busy", 64'(bus.busy), 64'd0);
      chk("reset_done", 64'(bus.done), 64'd0);
      chk("reset_err", 64'(bus.err), 64'd0);
      chk("reset_cur_rate", 64'(bus.cur_rate), 64'd0);
      chk("reset_apb", 64'({bus.psel, bus.penable, bus.pwrite, bus.paddr, bus.pwdata}), 64'd0);
      reset = 1'b0;
      @(negedge clk);

      run_seq(0, 1, 0, 0, 0);
      run_seq(2, 0, 0, 0, 0);
      run_seq(1, 0, 2, 0, 0);
      run_seq(3, 1, 0, 0, 1);
      run_seq(1, 1, 0, 1, 0);
      repeat (12)
         run_seq($urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 2),
                 ($urandom_range(0, 3) == 0) ? 1 : 0, ($urandom_range(0, 3) == 0) ? 1 : 0);
      run_seq(2, 1, 0, 0, 0);
      reset_mid_seq(3);
      run_seq(1, 1, 1, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
